// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the RV32I instruction memory
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_FLUSH, S_DONE, S_ERROR
   } state_t;

   localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

   state_t      state, state_nx;
   logic [15:0] n_words;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic        accept;
   logic        word_end;
   logic        last_word;
   logic        too_big;
   logic        empty_img;
   logic        session_start;

   assign accept        = in_valid && in_ready;
   assign word_end      = accept && (state == S_DATA) && (byte_cnt == 2'd3);
   assign last_word     = (word_idx + 16'd1) == n_words;
   assign too_big       = {17'd0, in_data, n_words[7:0]} > CAPACITY;
   assign empty_img     = {in_data, n_words[7:0]} == 16'd0;
   assign session_start = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      core_hold = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: if (start) state_nx = S_LEN0;
         S_LEN0: begin
            in_ready = 1'b1;
            if (accept) state_nx = S_LEN1;
         end
         S_LEN1: begin
            in_ready = 1'b1;
            if (accept) begin
               if (empty_img)    state_nx = S_DONE;
               else if (too_big) state_nx = S_ERROR;
               else              state_nx = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (word_end && last_word) state_nx = S_FLUSH;
         end
         S_FLUSH: state_nx = S_DONE;
         S_DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
            if (start) state_nx = S_LEN0;
         end
         S_ERROR: begin
            err = 1'b1;
            if (start) state_nx = S_LEN0;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Write port is registered so the strobe lands the cycle after the 4th byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_words   <= 16'd0;
         word_idx  <= 16'd0;
         byte_cnt  <= 2'd0;
         word_buf  <= 24'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (session_start) begin
            n_words  <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
         end else if (accept) begin
            case (state)
               S_LEN0: n_words[7:0]  <= in_data;
               S_LEN1: n_words[15:8] <= in_data;
               S_DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= in_data;
                     2'd1: word_buf[15:8]  <= in_data;
                     2'd2: word_buf[23:16] <= in_data;
                     default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {14'd0, word_idx, 2'b00};
                        mem_wdata <= {in_data, word_buf};
                        word_idx  <= word_idx + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_hold;
   logic        done;
   logic        err;

   int tests = 0;
   int fails = 0;

   int unsigned exp_words[$];
   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];

   imem_loader #(.ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         cap_addr.push_back(mem_addr);
         cap_data.push_back(mem_wdata);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      acc = 1'b0;
      for (int g = 0; g < 3 && $urandom_range(99) < gap; g++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 16 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         tests++; fails++;
         $display("FAIL accept_timeout byte=%02h in_ready=%b required 1", b, in_ready);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Loads exp_words as an image; expected writes follow from the stream format alone.
   task automatic do_load(input int gap, input bit noisy);
      int n;
      logic [31:0] w;
      n = exp_words.size();
      cap_addr.delete(); cap_data.delete();
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (2) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      pulse_start();
      tests++;
      if (in_ready !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL load_start ready/hold/done/err=%b%b%b%b required 1100", in_ready, core_hold, done, err);
      end
      send_byte(8'(n), gap);
      send_byte(8'(n >> 8), gap);
      if (n == 0) begin
         @(negedge clk);
         tests++;
         if (done !== 1'b1 || core_hold !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_done done/hold/ready=%b%b%b required 100", done, core_hold, in_ready);
         end
      end else begin
         for (int i = 0; i < n; i++) begin
            w = exp_words[i];
            for (int b = 0; b < 4; b++) begin
               if (noisy && i == n - 1 && b == 3) start = 1'b1;
               send_byte(w[8*b +: 8], gap);
            end
         end
         @(negedge clk);
         tests++;
         if (mem_we !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
            fails++;
            $display("FAIL flush_cycle we/done/hold=%b%b%b required 101", mem_we, done, core_hold);
         end
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         tests++;
         if (done !== 1'b1 || core_hold !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL load_done done/hold/we/err=%b%b%b%b required 1000", done, core_hold, mem_we, err);
         end
      end
      @(posedge clk); #1;
      repeat (2) begin @(posedge clk); #1; end
      tests++;
      if (cap_addr.size() != n) begin
         fails++;
         $display("FAIL write_count got=%0d required=%0d", cap_addr.size(), n);
      end
      for (int i = 0; i < n && i < cap_addr.size(); i++) begin
         tests++;
         if (cap_addr[i] !== 32'(i * 4) || cap_data[i] !== exp_words[i]) begin
            fails++;
            $display("FAIL write[%0d] addr=%08h data=%08h required addr=%08h data=%08h",
                     i, cap_addr[i], cap_data[i], 32'(i * 4), exp_words[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #3;
      tests++;
      if (core_hold !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_values hold/ready/we/done/err=%b%b%b%b%b addr=%08h data=%08h required 10000 0 0",
                  core_hold, in_ready, mem_we, done, err, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      in_valid = 1'b1; in_data = 8'hA5;
      repeat (3) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      tests++;
      if (core_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          mem_we !== 1'b0 || cap_addr.size() != 0) begin
         fails++;
         $display("FAIL idle_after_reset hold/ready/done/err/we=%b%b%b%b%b writes=%0d required 10000 0",
                  core_hold, in_ready, done, err, mem_we, cap_addr.size());
      end
   endtask

   task automatic test_two_word();
      logic [7:0] seq [10];
      seq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      cap_addr.delete(); cap_data.delete();
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(seq[i], 0);
      @(negedge clk);
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h00100093 || done !== 1'b0) begin
         fails++;
         $display("FAIL two_word_last we=%b addr=%08h data=%08h done=%b required 1 4 00100093 0",
                  mem_we, mem_addr, mem_wdata, done);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b1 || core_hold !== 1'b0) begin
         fails++;
         $display("FAIL two_word_done done=%b hold=%b required 1 0", done, core_hold);
      end
      @(posedge clk); #1;
      tests++;
      if (cap_addr.size() != 2 || cap_addr[0] !== 32'h0 || cap_data[0] !== 32'h00500013) begin
         fails++;
         $display("FAIL two_word_first writes=%0d addr=%08h data=%08h required 2 0 00500013",
                  cap_addr.size(), cap_addr[0], cap_data[0]);
      end
   endtask

   task automatic test_empty();
      exp_words.delete();
      do_load(0, 1'b0);
   endtask

   task automatic test_overflow();
      cap_addr.delete(); cap_data.delete();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      @(negedge clk);
      tests++;
      if (err !== 1'b1 || in_ready !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL overflow err/ready/hold/done=%b%b%b%b required 1010", err, in_ready, core_hold, done);
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h77;
      repeat (4) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      tests++;
      if (cap_addr.size() != 0 || err !== 1'b1) begin
         fails++;
         $display("FAIL overflow_nowrite writes=%0d err=%b required 0 1", cap_addr.size(), err);
      end
      exp_words.delete();
      exp_words.push_back($urandom);
      do_load(0, 1'b0);
   endtask

   task automatic test_gapped_reload();
      exp_words.delete();
      exp_words.push_back(32'h00500013);
      exp_words.push_back(32'h00100093);
      do_load(40, 1'b1);
      exp_words.delete();
      for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
      do_load(20, 1'b0);
   endtask

   task automatic test_reset_mid();
      cap_addr.delete(); cap_data.delete();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      rst = 1'b0;
      #2;
      tests++;
      if (core_hold !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || mem_addr !== 32'd0) begin
         fails++;
         $display("FAIL mid_reset hold/ready/we/done/err=%b%b%b%b%b addr=%08h required 10000 0",
                  core_hold, in_ready, mem_we, done, err, mem_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      tests++;
      if (cap_addr.size() != 0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_quiet writes=%0d ready=%b required 0 0", cap_addr.size(), in_ready);
      end
      exp_words.delete();
      exp_words.push_back($urandom);
      do_load(0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         exp_words.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) exp_words.push_back($urandom);
         do_load(30, 1'($urandom_range(1)));
      end
   endtask

   task automatic test_full_capacity();
      exp_words.delete();
      for (int i = 0; i < 1024; i++) exp_words.push_back($urandom);
      do_load(0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_empty();
      test_overflow();
      test_gapped_reload();
      test_reset_mid();
      test_random();
      test_full_capacity();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
